// File: rtl/worm_pkg.sv
// Shared constants, opcode encodings and FSM state type for the worm stepper.
package worm_pkg;
  localparam int   POS_W    = 5;
  localparam int   POS_MAX  = 15;
  localparam int   MAX_STEP = 3;
  localparam int   STEP_W   = 2;
  localparam int   CNT_W    = 4;
  localparam logic OP_INC   = 1'b0;
  localparam logic OP_DEC   = 1'b1;

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, DONE, ERR} state_e;
endpackage

// File: rtl/worm_step_calc.sv
// Combinational step/direction computation from current and target position.
module worm_step_calc import worm_pkg::*; #(
  parameter int PW = POS_W,
  parameter int MS = MAX_STEP
) (
  input  logic [PW-1:0]     cur,
  input  logic [PW-1:0]     target,
  output logic [STEP_W-1:0] steps,
  output logic              opcode,
  output logic              at_target
);
  // One extra bit so the magnitude never wraps.
  logic [PW:0] diff;

  always_comb begin
    at_target = (cur == target);
    opcode    = (target < cur) ? OP_DEC : OP_INC;
    diff      = (opcode == OP_DEC) ? ({1'b0, cur} - {1'b0, target})
                                   : ({1'b0, target} - {1'b0, cur});
    steps     = (diff > (PW+1)'(MS)) ? STEP_W'(MS) : diff[STEP_W-1:0];
  end
endmodule

// File: rtl/worm_stepper.sv
// Drives a worm toward a latched target with bounded steps, detecting stalls.
// Optional command-count timeout: define WORM_STEPPER_TIMEOUT_EN.
module worm_stepper #(
  parameter int POS_W    = worm_pkg::POS_W,
  parameter int POS_MAX  = worm_pkg::POS_MAX,
  parameter int MAX_STEP = worm_pkg::MAX_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [POS_W-1:0] target,
  input  logic [POS_W-1:0] cur,
  output logic [1:0]       steps,
  output logic             opcode,
  output logic             busy,
  output logic             done,
  output logic             err
);
  import worm_pkg::*;

  state_e           state_q, state_d;
  logic [POS_W-1:0] tgt_q, tgt_d;
  logic [POS_W-1:0] prev_q, prev_d;
  logic [1:0]       steps_q, steps_d;
  logic             opcode_q, opcode_d;
  logic             issued_q, issued_d;
  logic [1:0]       calc_steps;
  logic             calc_op;
  logic             at_tgt;
  logic             tgt_legal;

`ifdef WORM_STEPPER_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed_out;
  assign timed_out = (cnt_q == '1);
`endif

  assign tgt_legal = ({1'b0, target} <= (POS_W+1)'(POS_MAX));

  worm_step_calc #(.PW(POS_W), .MS(MAX_STEP)) u_calc (
    .cur       (cur),
    .target    (tgt_q),
    .steps     (calc_steps),
    .opcode    (calc_op),
    .at_target (at_tgt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      prev_q   <= '0;
      steps_q  <= '0;
      opcode_q <= OP_INC;
      issued_q <= 1'b0;
`ifdef WORM_STEPPER_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      prev_q   <= prev_d;
      steps_q  <= steps_d;
      opcode_q <= opcode_d;
      issued_q <= issued_d;
`ifdef WORM_STEPPER_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = tgt_legal ? ISSUE : ERR;
      // Stall only counts once a command has actually been issued this move.
      ISSUE:  if (at_tgt)                        state_d = DONE;
              else if (issued_q && cur == prev_q) state_d = ERR;
              else                                state_d = SETTLE;
`ifdef WORM_STEPPER_TIMEOUT_EN
      // The 15th command is the last one allowed; abort once it has settled.
      SETTLE: state_d = timed_out ? ERR : ISSUE;
`else
      SETTLE: state_d = ISSUE;
`endif
      DONE:   state_d = IDLE;
      ERR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tgt_d    = tgt_q;
    prev_d   = prev_q;
    opcode_d = opcode_q;
    issued_d = issued_q;
    steps_d  = '0;
`ifdef WORM_STEPPER_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    if (state_q == IDLE && start && tgt_legal) begin
      tgt_d    = target;
      issued_d = 1'b0;
`ifdef WORM_STEPPER_TIMEOUT_EN
      cnt_d    = '0;
`endif
    end
    if (state_q == ISSUE && state_d == SETTLE) begin
      steps_d  = calc_steps;
      opcode_d = calc_op;
      prev_d   = cur;
      issued_d = 1'b1;
`ifdef WORM_STEPPER_TIMEOUT_EN
      cnt_d    = cnt_q + 1'b1;
`endif
    end
  end

  always_comb begin
    busy = (state_q == ISSUE) || (state_q == SETTLE);
    done = (state_q == DONE);
    err  = (state_q == ERR);
  end

  assign steps  = steps_q;
  assign opcode = opcode_q;
endmodule

// File: tb/tb_worm_stepper.sv
// Self-checking bench: saturating worm model plus a move-level reference model.
module tb_worm_stepper;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [4:0] target, cur;
  logic [1:0] steps;
  logic       opcode, busy, done, err;

  int checks = 0;
  int failures = 0;

  // Worm behaviour: 0 = moves by steps, 1 = frozen, 2 = moves 1 per command.
  int         wmode = 0;
  logic       cur_load = 1'b1;
  logic [4:0] cur_load_val = 5'd0;

  logic [2:0] exp_cmds[$];
  bit         exp_done;
  int         exp_idx;
  int         exp_final;

  always #5 clk = ~clk;

  worm_stepper dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .cur(cur),
    .steps(steps), .opcode(opcode), .busy(busy), .done(done), .err(err)
  );

  function automatic logic [4:0] sat_move(input int c, input logic dec, input int mag);
    int nv;
    nv = dec ? c - mag : c + mag;
    if (nv < 0)  nv = 0;
    if (nv > 15) nv = 15;
    return 5'(nv);
  endfunction

  always @(posedge clk) begin
    if (cur_load)                   cur <= cur_load_val;
    else if (steps != 0 && wmode == 0) cur <= sat_move(int'(cur), opcode, int'(steps));
    else if (steps != 0 && wmode == 2) cur <= sat_move(int'(cur), opcode, 1);
  end

  // Whole-move reference: command list, outcome and pulse cycle after the start edge.
  task automatic ref_move(input int c0, input int t, input int mode);
    int c, prev, n, s;
    logic dec;
    exp_cmds.delete();
    n = 0; c = c0; prev = -1;
    if (t > 15) begin
      exp_done = 0; exp_idx = 1; exp_final = c0;
      return;
    end
    forever begin
      if (c == t) begin exp_done = 1; exp_idx = 2*n + 2; break; end
      if (n > 0 && c == prev) begin exp_done = 0; exp_idx = 2*n + 2; break; end
      s = (t > c) ? t - c : c - t;
      if (s > 3) s = 3;
      dec = (t < c);
      exp_cmds.push_back({dec, 2'(s)});
      prev = c; n++;
      if (mode == 0)      c = int'(sat_move(c, dec, s));
      else if (mode == 2) c = int'(sat_move(c, dec, 1));
`ifdef WORM_STEPPER_TIMEOUT_EN
      if (n == 15) begin exp_done = 0; exp_idx = 2*n + 1; break; end
`endif
    end
    exp_final = c;
  endtask

  task automatic run_move(input int c0, input int t, input int mode, input string nm);
    logic [2:0] got[$];
    int  k;
    bit  seen, busy_bad, g_done, g_err, cmd_bad;
    wmode = mode;
    cur_load = 1'b1; cur_load_val = 5'(c0);
    @(posedge clk); #1;
    cur_load = 1'b0;
    ref_move(c0, t, mode);
    start = 1'b1; target = 5'(t);
    @(posedge clk); #1;
    start = 1'b0;
    k = 1; seen = 0; busy_bad = 0; g_done = 0; g_err = 0;
    while (k <= 200) begin
      if (steps != 0) got.push_back({opcode, steps});
      if (done || err) begin
        seen = 1; g_done = done; g_err = err;
        if (busy) busy_bad = 1;
        break;
      end
      if (!busy) busy_bad = 1;
      // Start and target noise while busy must be ignored.
      start = 1'($urandom_range(0, 1));
      target = 5'($urandom);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    checks++;
    if (!seen) begin failures++; $display("FAIL %s pulse: none within %0d cycles, want one", nm, k); end
    checks++;
    if ({g_done, g_err} !== {exp_done, !exp_done}) begin
      failures++;
      $display("FAIL %s outcome: got done=%0d err=%0d, want done=%0d err=%0d", nm, g_done, g_err, exp_done, !exp_done);
    end
    checks++;
    if (k !== exp_idx) begin failures++; $display("FAIL %s latency: got %0d, want %0d", nm, k, exp_idx); end
    checks++;
    if (busy_bad) begin failures++; $display("FAIL %s busy: got wrong level during move, want high until pulse", nm); end
    cmd_bad = (got.size() != exp_cmds.size());
    if (!cmd_bad) foreach (got[i]) if (got[i] !== exp_cmds[i]) cmd_bad = 1;
    checks++;
    if (cmd_bad) begin
      failures++;
      $display("FAIL %s commands: got %0d cmds %p, want %0d cmds %p", nm, got.size(), got, exp_cmds.size(), exp_cmds);
    end
    checks++;
    if (int'(cur) !== exp_final) begin failures++; $display("FAIL %s final_cur: got %0d, want %0d", nm, cur, exp_final); end
    @(posedge clk); #1;
    checks++;
    if ({busy, done, err, steps} !== 5'b0) begin
      failures++;
      $display("FAIL %s idle_after: got busy=%b done=%b err=%b steps=%0d, want all 0", nm, busy, done, err, steps);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; target = 5'd7;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({steps, opcode, busy, done, err} !== 6'b0) begin
      failures++;
      $display("FAIL reset: got steps=%0d op=%b busy=%b done=%b err=%b, want all 0", steps, opcode, busy, done, err);
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_move(2, 9, 0, "move_2_9");
    run_move(12, 12, 0, "same_12");
    run_move(3, 20, 0, "illegal_20");
    run_move(5, 0, 1, "stall_5_0");
    run_move(15, 0, 0, "move_15_0");
  endtask

  task automatic test_reset_mid_move();
    int  n;
    bit  hit, bad;
    wmode = 0;
    cur_load = 1'b1; cur_load_val = 5'd0;
    @(posedge clk); #1;
    cur_load = 1'b0;
    start = 1'b1; target = 5'd15;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0;
    for (n = 0; n < 10; n++) begin
      if (steps != 0) begin hit = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL rst_mid settle: got no SETTLE within 10 cycles, want one"); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({steps, opcode, busy, done, err} !== 6'b0) begin
      failures++;
      $display("FAIL rst_mid outputs: got steps=%0d op=%b busy=%b done=%b err=%b, want all 0", steps, opcode, busy, done, err);
    end
    rst = 1'b0;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy || done || err || steps != 0) bad = 1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL rst_mid quiet: got activity after reset, want idle"); end
    run_move(4, 12, 0, "post_rst");
  endtask

  task automatic test_timeout();
    run_move(0, 15, 2, "slow_0_15");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      int c0, t;
      c0 = $urandom_range(0, 15);
      t  = ($urandom_range(0, 5) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 15);
      run_move(c0, t, 0, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    run_move(0, 13, 0, "b2b_a");
    run_move(13, 1, 0, "b2b_b");
    run_move(1, 1, 0, "b2b_c");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; target = 5'd0;
    test_reset();
    test_directed();
    test_reset_mid_move();
    test_timeout();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
